// File: rtl/iadc_decimator.sv
// Decimation back-end for the incremental delta-sigma ADC: one conversion per
// start, second-order cascade-of-integrators over OSR samples, valid/ready result.
module iadc_decimator #(
    parameter int OSR_W = 10,
    parameter int ACC_W = 24
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [OSR_W-1:0] osr_i,
    input  logic             mod_bit_i,
    output logic             mod_rst_o,
    output logic             mod_en_o,
    output logic             busy_o,
    output logic [ACC_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic             clr_ovr_i,
    output logic             overrun_o
);

    typedef enum logic [1:0] {IDLE, MRST, CONV} state_t;

    state_t                   state_reg, state_next;
    logic [OSR_W-1:0]         osr_reg, osr_next;
    logic [OSR_W-1:0]         cnt_reg, cnt_next;
    logic signed [ACC_W-1:0]  acc1_reg, acc1_next;
    logic signed [ACC_W-1:0]  acc2_reg, acc2_next;
    logic signed [ACC_W-1:0]  data_reg, data_next;
    logic signed [ACC_W-1:0]  step;
    logic                     done_reg, done_next;
    logic                     valid_reg, valid_next;
    logic                     overrun_reg, overrun_next;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            osr_reg     <= '0;
            cnt_reg     <= '0;
            acc1_reg    <= '0;
            acc2_reg    <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            osr_reg     <= osr_next;
            cnt_reg     <= cnt_next;
            acc1_reg    <= acc1_next;
            acc2_reg    <= acc2_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        osr_next     = osr_reg;
        cnt_next     = cnt_reg;
        acc1_next    = acc1_reg;
        acc2_next    = acc2_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        valid_next   = valid_reg;
        overrun_next = overrun_reg & ~clr_ovr_i;
        step         = mod_bit_i ? ACC_W'(1) : {ACC_W{1'b1}};

        case (state_reg)
            IDLE: begin
                if (start_i && (osr_i != '0)) begin
                    osr_next   = osr_i;
                    cnt_next   = '0;
                    acc1_next  = '0;
                    acc2_next  = '0;
                    state_next = MRST;
                end
            end
            MRST: state_next = CONV;
            CONV: begin
                // acc2 integrates the already-updated acc1
                acc1_next = acc1_reg + step;
                acc2_next = acc2_reg + acc1_reg + step;
                cnt_next  = cnt_reg + OSR_W'(1);
                if (cnt_reg == osr_reg - OSR_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Result lands one cycle after the last sample; a same-cycle
        // handshake consumes the old result, so no overrun then.
        if (done_reg) begin
            data_next  = acc2_reg;
            valid_next = 1'b1;
            if (valid_reg && !ready_i) begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && ready_i) begin
            valid_next = 1'b0;
        end
    end

    assign mod_rst_o = wb_rst_i | (state_reg == MRST);
    assign mod_en_o  = (state_reg == CONV);
    assign busy_o    = (state_reg != IDLE);
    assign data_o    = data_reg;
    assign valid_o   = valid_reg;
    assign overrun_o = overrun_reg;

endmodule

// File: tb/tb_iadc_decimator.sv
// Directed self-checking bench for iadc_decimator: timing, arithmetic,
// handshake/overrun behaviour, ignored starts and mid-conversion reset.
module tb_iadc_decimator;

    localparam int OSR_W = 10;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [OSR_W-1:0] osr;
    logic             mod_bit;
    logic             mod_rst;
    logic             mod_en;
    logic             busy;
    logic [ACC_W-1:0] data;
    logic             valid;
    logic             ready;
    logic             clr_ovr;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    iadc_decimator #(.OSR_W(OSR_W), .ACC_W(ACC_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start),
        .osr_i     (osr),
        .mod_bit_i (mod_bit),
        .mod_rst_o (mod_rst),
        .mod_en_o  (mod_en),
        .busy_o    (busy),
        .data_o    (data),
        .valid_o   (valid),
        .ready_i   (ready),
        .clr_ovr_i (clr_ovr),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    // Runs one conversion; j counts negedges after the start edge t.
    // Ends at the negedge after edge t+n+2. A second start (osr 7) is
    // pulsed at j == start_at to exercise the busy-ignore path.
    task automatic do_conv(input int n, input logic [1023:0] bits, input int start_at,
                           output int en_cnt, output int busy_cnt, output int rst_cnt,
                           output logic valid_pre, output logic valid_post);
        en_cnt = 0; busy_cnt = 0; rst_cnt = 0;
        valid_pre = 1'b0; valid_post = 1'b0;
        @(negedge clk);
        start = 1'b1;
        osr   = OSR_W'(n);
        @(negedge clk);
        for (int j = 0; j <= n + 2; j++) begin
            if (mod_en)  en_cnt++;
            if (busy)    busy_cnt++;
            if (mod_rst) rst_cnt++;
            if (j == n + 1) valid_pre  = valid;
            if (j == n + 2) valid_post = valid;
            if (j == start_at) begin
                start = 1'b1;
                osr   = 10'd7;
            end else begin
                start = 1'b0;
            end
            mod_bit = (j >= 1 && j <= n) ? bits[j-1] : 1'b0;
            if (j < n + 2) @(negedge clk);
        end
        start = 1'b0;
        $display("conv n=%0d en=%0d busy=%0d mrst=%0d data=%0d valid=%b ovr=%b",
                 n, en_cnt, busy_cnt, rst_cnt, $signed(data), valid, overrun);
    endtask

    task automatic consume();
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; osr = '0; mod_bit = 1'b0;
        ready = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mod_rst !== 1'b1) begin failures++; $display("FAIL reset_mod_rst got=%b exp=1", mod_rst); end
        checks++; if (busy !== 1'b0 || mod_en !== 1'b0) begin failures++; $display("FAIL reset_busy_en got=%b%b exp=00", busy, mod_en); end
        checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_valid_ovr got=%b%b exp=00", valid, overrun); end
        checks++; if (data !== 24'd0) begin failures++; $display("FAIL reset_data got=%h exp=000000", data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mod_rst !== 1'b0) begin failures++; $display("FAIL post_reset_mod_rst got=%b exp=0", mod_rst); end
        $display("reset done");
    endtask

    task automatic test_basic();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        do_conv(4, 1024'hF, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (rst_c !== 1) begin failures++; $display("FAIL basic_mrst_cycles got=%0d exp=1", rst_c); end
        checks++; if (en_c !== 4) begin failures++; $display("FAIL basic_en_cycles got=%0d exp=4", en_c); end
        checks++; if (busy_c !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", busy_c); end
        checks++; if (vpre !== 1'b0 || vpost !== 1'b1) begin failures++; $display("FAIL basic_latency valid@5/6 got=%b%b exp=01", vpre, vpost); end
        checks++; if (data !== 24'd10) begin failures++; $display("FAIL basic_data got=%0d exp=10", $signed(data)); end
        consume();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_handshake valid got=%b exp=0", valid); end
    endtask

    task automatic test_long();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        do_conv(1023, '0, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (busy_c !== 1024) begin failures++; $display("FAIL long_busy_cycles got=%0d exp=1024", busy_c); end
        checks++; if (en_c !== 1023) begin failures++; $display("FAIL long_en_cycles got=%0d exp=1023", en_c); end
        checks++; if (data !== 24'hF80200 || vpost !== 1'b1) begin failures++; $display("FAIL long_data got=%h valid=%b exp=f80200 valid=1", data, vpost); end
        consume();
    endtask

    task automatic test_patterns();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        do_conv(4, 1024'b0101, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (data !== 24'd2) begin failures++; $display("FAIL pattern_1010 got=%0d exp=2", $signed(data)); end
        consume();
        do_conv(5, 1024'b00011, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (data !== 24'd3) begin failures++; $display("FAIL pattern_11000 got=%0d exp=3", $signed(data)); end
        consume();
    endtask

    task automatic test_back_to_back();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        do_conv(4, 1024'b0101, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (overrun !== 1'b0 || data !== 24'd2) begin failures++; $display("FAIL b2b_first ovr=%b data=%0d exp ovr=0 data=2", overrun, $signed(data)); end
        do_conv(4, 1024'hF, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
        checks++; if (data !== 24'd10 || valid !== 1'b1) begin failures++; $display("FAIL b2b_data got=%0d valid=%b exp=10 valid=1", $signed(data), valid); end
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0 || valid !== 1'b1) begin failures++; $display("FAIL b2b_clear ovr=%b valid=%b exp ovr=0 valid=1", overrun, valid); end
        consume();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_consume valid got=%b exp=0", valid); end
        $display("back_to_back done ovr=%b valid=%b", overrun, valid);
    endtask

    task automatic test_ignored();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        @(negedge clk); start = 1'b1; osr = '0;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b0 || mod_rst !== 1'b0) begin failures++; $display("FAIL osr0_ignored busy=%b mrst=%b exp 0 0", busy, mod_rst); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL osr0_no_result busy=%b valid=%b exp 0 0", busy, valid); end
        do_conv(4, 1024'hF, 2, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (busy_c !== 5 || en_c !== 4) begin failures++; $display("FAIL busy_start_timing busy=%0d en=%0d exp 5 4", busy_c, en_c); end
        checks++; if (data !== 24'd10 || vpost !== 1'b1) begin failures++; $display("FAIL busy_start_data got=%0d valid=%b exp=10 valid=1", $signed(data), vpost); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_no_restart busy=%b exp=0", busy); end
    endtask

    task automatic test_midreset();
        int en_c, busy_c, rst_c; logic vpre, vpost;
        @(negedge clk); start = 1'b1; osr = 10'd8; mod_bit = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mod_en !== 1'b1) begin failures++; $display("FAIL midrst_in_conv mod_en=%b exp=1", mod_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || mod_en !== 1'b0) begin failures++; $display("FAIL midrst_state busy=%b valid=%b en=%b exp 0 0 0", busy, valid, mod_en); end
        checks++; if (data !== 24'd0) begin failures++; $display("FAIL midrst_data got=%h exp=000000", data); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_aborted valid=%b busy=%b exp 0 0", valid, busy); end
        do_conv(5, 1024'b00011, -1, en_c, busy_c, rst_c, vpre, vpost);
        checks++; if (data !== 24'd3 || vpost !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_fresh data=%0d valid=%b ovr=%b exp 3 1 0", $signed(data), vpost, overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_patterns();
        test_back_to_back();
        test_ignored();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
